// File: rtl/hub75_pkg.sv
// Shared HUB75 constants: panel geometry, pin packing and drain FSM encoding.
package hub75_pkg;
  localparam int WIDTH     = 64;
  localparam int ROWS      = 32;
  localparam int BIT_DEPTH = 8;
  localparam int OE_W      = 16;

  localparam int ADDR_W  = $clog2(ROWS);
  localparam int COL_W   = $clog2(WIDTH);
  localparam int PLANE_W = $clog2(BIT_DEPTH);
  localparam int RGB_W   = 6;

  // Bit positions inside hub_rgb / m_rgb: {b2,b1,g2,g1,r2,r1}
  localparam int RGB_R1 = 0;
  localparam int RGB_R2 = 1;
  localparam int RGB_G1 = 2;
  localparam int RGB_G2 = 3;
  localparam int RGB_B1 = 4;
  localparam int RGB_B2 = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef struct packed {
    logic              clk;
    logic              lat;
    logic              oe;
    logic [ADDR_W-1:0] addr;
    logic [RGB_W-1:0]  rgb;
  } pins_t;

  // Pins as seen from an idle driver: blanked, no clock, no latch
  localparam pins_t PINS_IDLE = '{clk: 1'b0, lat: 1'b0, oe: 1'b1, addr: '0, rgb: '0};

  function automatic logic [PLANE_W-1:0] next_plane(input logic [PLANE_W-1:0] p);
    return (p == PLANE_W'(BIT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/hub75_line_buffer.sv
// Two WIDTH x 6 row banks with one fill-side write port, one drain-side
// read port and a pending flag per bank (committed but not yet drained).
module hub75_line_buffer
  import hub75_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [COL_W-1:0] wr_col,
  input  logic [RGB_W-1:0] wr_data,
  input  logic             commit_en,
  input  logic             commit_bank,
  input  logic             release_en,
  input  logic             release_bank,
  input  logic             rd_bank,
  input  logic [COL_W-1:0] rd_col,
  output logic [RGB_W-1:0] rd_data,
  output logic [1:0]       pending
);
  logic [RGB_W-1:0] mem [2*WIDTH];

  // Pixel storage is not reset; stale slots legitimately show through on short rows
  always_ff @(posedge CLK) begin
    if (wr_en) mem[{wr_bank, wr_col}] <= wr_data;
  end

  assign rd_data = mem[{rd_bank, rd_col}];

  // A commit marks a bank full; the drain side frees it after its last beat
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (commit_en && commit_bank == 1'(b)) pending[b] <= 1'b1;
        else if (release_en && release_bank == 1'(b)) pending[b] <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/hub75_rx.sv
// HUB75 receive endpoint: samples the driver pins, rebuilds each latched
// row / bit-plane into a double buffer and streams it out column by column.
module hub75_rx
  import hub75_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               hub_clk,
  input  logic               hub_lat,
  input  logic               hub_oe,
  input  logic [ADDR_W-1:0]  hub_addr,
  input  logic [RGB_W-1:0]   hub_rgb,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [COL_W-1:0]   m_col,
  output logic [ADDR_W-1:0]  m_row,
  output logic [PLANE_W-1:0] m_plane,
  output logic [RGB_W-1:0]   m_rgb,
  output logic               m_last,
  output logic [OE_W-1:0]    m_oe_cycles,
  output logic               err_len,
  output logic               err_ovf
);
  pins_t s1, s2;
  logic  s3_clk, s3_lat;
  logic  clk_rise, lat_rise;

  // Two synchronizer stages plus a history flop for edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1     <= PINS_IDLE;
      s2     <= PINS_IDLE;
      s3_clk <= 1'b0;
      s3_lat <= 1'b0;
    end else begin
      s1     <= '{clk: hub_clk, lat: hub_lat, oe: hub_oe, addr: hub_addr, rgb: hub_rgb};
      s2     <= s1;
      s3_clk <= s2.clk;
      s3_lat <= s2.lat;
    end
  end

  assign clk_rise = s2.clk & ~s3_clk;
  assign lat_rise = s2.lat & ~s3_lat;

  logic [COL_W:0]   col_cnt, col_next;
  logic [OE_W-1:0]  oe_cnt, oe_next;
  logic             fill_bank;
  logic [1:0]       pending;
  logic             drop, do_commit, wr_en;
  logic             col_room;

  assign col_room  = col_cnt < (COL_W+1)'(WIDTH);
  assign col_next  = (clk_rise && col_room) ? col_cnt + 1'b1 : col_cnt;
  assign oe_next   = (!s2.oe && oe_cnt != {OE_W{1'b1}}) ? oe_cnt + 1'b1 : oe_cnt;
  assign drop      = lat_rise && (&pending);
  assign do_commit = lat_rise && !drop;
  // A bank still awaiting drain is never overwritten by the fill side
  assign wr_en     = clk_rise && col_room && !pending[fill_bank];

  // Fill-side column and blank-time counters; a latch restarts both
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_cnt   <= '0;
      oe_cnt    <= '0;
      fill_bank <= 1'b0;
    end else if (lat_rise) begin
      col_cnt <= '0;
      oe_cnt  <= '0;
      if (!drop) fill_bank <= ~fill_bank;
    end else begin
      col_cnt <= col_next;
      oe_cnt  <= oe_next;
    end
  end

  logic [ADDR_W-1:0]  prev_row;
  logic [PLANE_W-1:0] prev_plane, commit_plane;
  logic               prev_valid;

  assign commit_plane = (prev_valid && s2.addr == prev_row) ? next_plane(prev_plane) : '0;

  // Plane history only advances on rows that are actually committed
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_valid <= 1'b0;
      prev_row   <= '0;
      prev_plane <= '0;
    end else if (do_commit) begin
      prev_valid <= 1'b1;
      prev_row   <= s2.addr;
      prev_plane <= commit_plane;
    end
  end

  logic [ADDR_W-1:0]  meta_row   [2];
  logic [PLANE_W-1:0] meta_plane [2];
  logic [OE_W-1:0]    meta_oe    [2];

  // Per-bank row descriptor captured alongside the commit
  always_ff @(posedge CLK) begin
    if (do_commit) begin
      meta_row[fill_bank]   <= s2.addr;
      meta_plane[fill_bank] <= commit_plane;
      meta_oe[fill_bank]    <= oe_next;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_len <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      if (do_commit && col_next != (COL_W+1)'(WIDTH)) err_len <= 1'b1;
      if (drop) err_ovf <= 1'b1;
    end
  end

  logic [0:0]       state;
  logic             drain_bank;
  logic             beat_done, row_end, load, rd_bank;
  logic [COL_W-1:0] rd_col;
  logic [RGB_W-1:0] rd_data;

  assign beat_done = m_valid && m_ready;
  assign row_end   = (state == ST_SEND) && beat_done && (m_col == COL_W'(WIDTH - 1));

  hub75_line_buffer u_buf (
    .CLK          (CLK),
    .RST          (RST),
    .wr_en        (wr_en),
    .wr_bank      (fill_bank),
    .wr_col       (col_cnt[COL_W-1:0]),
    .wr_data      (s2.rgb),
    .commit_en    (do_commit),
    .commit_bank  (fill_bank),
    .release_en   (row_end),
    .release_bank (drain_bank),
    .rd_bank      (rd_bank),
    .rd_col       (rd_col),
    .rd_data      (rd_data),
    .pending      (pending)
  );

  // Pick the next beat to present: first column of a pending bank or the next column
  always_comb begin
    rd_bank = drain_bank;
    rd_col  = '0;
    load    = 1'b0;
    if (state == ST_IDLE) begin
      load = pending[drain_bank];
    end else if (beat_done) begin
      if (row_end) begin
        rd_bank = ~drain_bank;
        load    = pending[~drain_bank];
      end else begin
        rd_col = m_col + 1'b1;
        load   = 1'b1;
      end
    end
  end

  // Drain FSM with registered outputs that hold until the sink accepts
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      drain_bank  <= 1'b0;
      m_valid     <= 1'b0;
      m_col       <= '0;
      m_row       <= '0;
      m_plane     <= '0;
      m_rgb       <= '0;
      m_last      <= 1'b0;
      m_oe_cycles <= '0;
    end else begin
      if (row_end) drain_bank <= ~drain_bank;
      if (load) begin
        state       <= ST_SEND;
        m_valid     <= 1'b1;
        m_col       <= rd_col;
        m_rgb       <= rd_data;
        m_row       <= meta_row[rd_bank];
        m_plane     <= meta_plane[rd_bank];
        m_oe_cycles <= meta_oe[rd_bank];
        m_last      <= (rd_col == COL_W'(WIDTH - 1));
      end else if (row_end) begin
        state   <= ST_IDLE;
        m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hub75_rx.sv
// Self-checking bench for hub75_rx: drives driver-style pin sequences and
// compares every accepted beat against a row-level reference model.
module tb_hub75_rx;
  import hub75_pkg::*;

  typedef struct packed {
    logic [5:0]  col;
    logic [4:0]  row;
    logic [2:0]  plane;
    logic [5:0]  rgb;
    logic        last;
    logic [15:0] oe;
  } beat_t;

  logic        CLK, RST;
  logic        hub_clk, hub_lat, hub_oe;
  logic [4:0]  hub_addr;
  logic [5:0]  hub_rgb;
  logic        m_valid, m_ready, m_last, err_len, err_ovf;
  logic [5:0]  m_col, m_rgb;
  logic [4:0]  m_row;
  logic [2:0]  m_plane;
  logic [15:0] m_oe_cycles;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int ready_mode = 1;
  int oe_left = 0;

  beat_t      beat_q[$];
  logic [5:0] bank_mem [2][64];
  logic [5:0] row_pix [64];
  int         model_fill = 0;
  logic       prev_valid = 1'b0;
  logic [4:0] prev_row = '0;
  logic [2:0] prev_plane = '0;
  logic       exp_len = 1'b0;
  logic       exp_ovf = 1'b0;

  hub75_rx dut (
    .CLK(CLK), .RST(RST), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe),
    .hub_addr(hub_addr), .hub_rgb(hub_rgb), .m_valid(m_valid), .m_ready(m_ready),
    .m_col(m_col), .m_row(m_row), .m_plane(m_plane), .m_rgb(m_rgb), .m_last(m_last),
    .m_oe_cycles(m_oe_cycles), .err_len(err_len), .err_ovf(err_ovf)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Sink ready: 0 stalled, 1 always ready, 2 random with ~75% acceptance
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(3, 0) != 0);
      endcase
    end
  end

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: each accepted beat against the model, stalled beats must hold
  logic        prev_stall = 1'b0;
  logic [37:0] prev_bus = '0;
  always @(negedge CLK) begin
    beat_t got, exp;
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check_output("hold", 64'({m_valid, m_col, m_row, m_plane, m_rgb, m_last, m_oe_cycles}), 64'(prev_bus));
      if (m_valid && m_ready) begin
        accepted++;
        got = '{col: m_col, row: m_row, plane: m_plane, rgb: m_rgb, last: m_last, oe: m_oe_cycles};
        checks++;
        assert (beat_q.size() != 0) else begin
          errors++;
          $error("[TB] FAIL spurious_beat got=%0h exp=none", got);
        end
        if (beat_q.size() != 0) begin
          exp = beat_q.pop_front();
          check_output("beat", 64'(got), 64'(exp));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_bus   = {m_valid, m_col, m_row, m_plane, m_rgb, m_last, m_oe_cycles};
    end
  end

  // One CLK cycle; also walks the blank-pin low window
  task automatic step();
    @(posedge CLK);
    #1;
    if (oe_left > 0) begin
      hub_oe = 1'b0;
      oe_left--;
    end else begin
      hub_oe = 1'b1;
    end
  endtask

  // Reference model of a latch: drop when two rows are still undrained,
  // otherwise fill the next bank and queue WIDTH beats
  task automatic model_latch(input logic [4:0] addr, input int ncols, input int oe_low);
    int         pend;
    logic [2:0] plane;
    beat_t      b;
    pend = (beat_q.size() + 63) / 64;
    if (pend >= 2) begin
      exp_ovf = 1'b1;
      return;
    end
    for (int c = 0; c < ncols && c < 64; c++) bank_mem[model_fill][c] = row_pix[c];
    plane = (prev_valid && addr == prev_row) ? ((prev_plane == 3'd7) ? 3'd0 : prev_plane + 3'd1) : 3'd0;
    if (ncols != 64) exp_len = 1'b1;
    for (int c = 0; c < 64; c++) begin
      b = '{col: 6'(c), row: addr, plane: plane, rgb: bank_mem[model_fill][c],
            last: (c == 63), oe: 16'(oe_low)};
      beat_q.push_back(b);
    end
    prev_valid = 1'b1;
    prev_row   = addr;
    prev_plane = plane;
    model_fill = 1 - model_fill;
  endtask

  // Shift ncols pixels from row_pix with hub_clk toggling every cycle, then latch
  task automatic send_row(input logic [4:0] addr, input int ncols, input int oe_low);
    hub_addr = addr;
    oe_left  = oe_low;
    for (int c = 0; c < ncols; c++) begin
      hub_rgb = row_pix[c];
      hub_clk = 1'b0;
      step();
      hub_clk = 1'b1;
      step();
    end
    hub_clk = 1'b0;
    step();
    while (oe_left > 0) step();
    model_latch(addr, ncols, oe_low);
    hub_lat = 1'b1;
    step();
    step();
    hub_lat = 1'b0;
    repeat (6) step();
    check_output("err_len", 64'(err_len), 64'(exp_len));
    check_output("err_ovf", 64'(err_ovf), 64'(exp_ovf));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && beat_q.size() != 0; i++) step();
    check_output("drain_done", 64'(beat_q.size()), 64'd0);
    repeat (10) step();
  endtask

  task automatic random_pixels();
    for (int c = 0; c < 64; c++) row_pix[c] = 6'($urandom);
  endtask

  function automatic logic [5:0] pattern_pix(input int p);
    logic [23:0] colour;
    logic [5:0]  px;
    colour = 24'h080301;
    px = '0;
    px[RGB_R1] = colour[16+p];
    px[RGB_R2] = colour[16+p];
    px[RGB_G1] = colour[8+p];
    px[RGB_G2] = colour[8+p];
    px[RGB_B1] = colour[p];
    px[RGB_B2] = colour[p];
    return px;
  endfunction

  initial begin
    int  acc0;
    bit  found;
    RST = 1'b1; hub_clk = 1'b0; hub_lat = 1'b0; hub_oe = 1'b1;
    hub_addr = '0; hub_rgb = '0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check_output("reset_bus", 64'({m_valid, m_col, m_row, m_plane, m_rgb, m_last, m_oe_cycles}), 64'd0);
    check_output("reset_err", 64'({err_len, err_ovf}), 64'd0);
    RST = 1'b0;
    step();

    $display("[TB] colour pattern, 8 planes at address 0");
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 64; c++) row_pix[c] = pattern_pix(p);
      send_row(5'd0, 64, $urandom_range(120, 0));
    end
    check_output("plane3_pix", 64'(pattern_pix(3)), 64'h03);
    wait_drain();

    $display("[TB] address change to 1");
    random_pixels();
    send_row(5'd1, 64, 20);
    wait_drain();

    $display("[TB] short row of 40 columns");
    random_pixels();
    send_row(5'd1, 40, 5);
    wait_drain();

    $display("[TB] blank low for 100 cycles");
    random_pixels();
    send_row(5'd9, 64, 100);
    wait_drain();

    $display("[TB] random rows with random sink stalls");
    ready_mode = 2;
    for (int r = 0; r < 10; r++) begin
      random_pixels();
      send_row(5'($urandom_range(4, 3)), 64, $urandom_range(120, 0));
    end
    wait_drain();
    ready_mode = 1;

    $display("[TB] sink stalled for three rows");
    ready_mode = 0;
    for (int r = 0; r < 3; r++) begin
      random_pixels();
      send_row(5'd2, 64, $urandom_range(60, 0));
    end
    acc0 = accepted;
    ready_mode = 1;
    wait_drain();
    check_output("ovf_beats", 64'(accepted - acc0), 64'd128);

    $display("[TB] reset during a drain");
    random_pixels();
    send_row(5'd7, 64, 30);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge CLK);
      if (m_valid && m_col == 6'd20) found = 1'b1;
    end
    check_output("beat20_seen", 64'(found), 64'd1);
    #1 RST = 1'b1;
    @(negedge CLK);
    check_output("rst_valid", 64'(m_valid), 64'd0);
    check_output("rst_err", 64'({err_len, err_ovf}), 64'd0);
    beat_q.delete();
    model_fill = 0;
    prev_valid = 1'b0;
    exp_len = 1'b0;
    exp_ovf = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    step();
    random_pixels();
    send_row(5'd7, 64, 12);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
